// File: rtl/fml_dmard_pkg.sv
// Shared constants for the FML burst-read streamer: CSR indices, FSM encoding,
// burst length and FIFO sizing.
package fml_dmard_pkg;

    localparam int BURST_LEN  = 4;
    localparam int BEAT_W     = $clog2(BURST_LEN);
    localparam int FIFO_DEPTH = 8;
    localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);
    localparam int FIFO_LVL_W = FIFO_PTR_W + 1;

    localparam logic [1:0] CSR_BASE  = 2'd0;
    localparam logic [1:0] CSR_COUNT = 2'd1;
    localparam logic [1:0] CSR_CTRL  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2
    } state_e;

endpackage

// File: rtl/fml_dmard_fifo.sv
// 64-bit show-ahead FIFO with level output; the head word is readable
// combinationally the cycle after it was pushed.
module fml_dmard_fifo
    import fml_dmard_pkg::*;
(
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  push_i,
    input  logic [63:0]           data_i,
    input  logic                  pop_i,
    output logic [63:0]           data_o,
    output logic                  empty_o,
    output logic [FIFO_LVL_W-1:0] level_o
);

    logic [63:0]           mem_q [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_LVL_W-1:0] level_q;
    logic                  do_pop;

    assign do_pop  = pop_i && (level_q != '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign empty_o = (level_q == '0);
    assign level_o = level_q;

    // NOTE: storage is deliberately not reset; pointers and level alone define emptiness.
    always_ff @(posedge sys_clk) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + FIFO_PTR_W'(1);
            if (do_pop) rd_ptr_q <= rd_ptr_q + FIFO_PTR_W'(1);
            level_q <= level_q + FIFO_LVL_W'(push_i) - FIFO_LVL_W'(do_pop);
        end
    end

endmodule

// File: rtl/fml_dmard.sv
// FML 4x64 burst-read DMA feeding a 64-bit word stream, programmed through CSRs.
// Optional completion interrupt: define FML_DMARD_IRQ_EN.
module fml_dmard
    import fml_dmard_pkg::*;
#(
    parameter logic [3:0] csr_addr  = 4'h0,
    parameter int         fml_depth = 26
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [13:0]          csr_a,
    input  logic                 csr_we,
    input  logic [31:0]          csr_di,
    output logic [31:0]          csr_do,
    output logic [fml_depth-1:0] fml_adr,
    output logic                 fml_stb,
    output logic                 fml_we,
    input  logic                 fml_ack,
    output logic [7:0]           fml_sel,
    input  logic [63:0]          fml_di,
    output logic [63:0]          str_data,
    output logic                 str_valid,
    input  logic                 str_ready,
    output logic                 irq
);

    localparam int RES_W = FIFO_LVL_W + 1;

    state_e                state_q, state_d;
    logic [fml_depth-1:0]  base_q, base_d, adr_q, adr_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic                  busy_q, busy_d, done_q, done_d, abort_q, abort_d;
    logic [31:0]           csr_do_q, csr_do_d;
    logic                  csr_sel, wr_base, wr_count, wr_ctrl, abort_req;
    logic                  fifo_push, fifo_empty, space_ok;
    logic [FIFO_LVL_W-1:0] fifo_level;
    logic [RES_W-1:0]      in_flight, reserved;
    logic                  unused_bits;

    assign csr_sel   = (csr_a[13:10] == csr_addr);
    assign wr_base   = csr_sel && csr_we && (csr_a[1:0] == CSR_BASE);
    assign wr_count  = csr_sel && csr_we && (csr_a[1:0] == CSR_COUNT);
    assign wr_ctrl   = csr_sel && csr_we && (csr_a[1:0] == CSR_CTRL);
    assign abort_req = wr_ctrl && csr_di[2];
    assign unused_bits = ^{csr_a[9:2], csr_di[31:fml_depth]};

    // Beats still to land count against free space so the FIFO can never overflow.
    assign in_flight = (state_q == ST_DATA) ? RES_W'(BURST_LEN) - RES_W'(beat_q) : '0;
    assign reserved  = RES_W'(fifo_level) + in_flight;
    assign space_ok  = (reserved <= RES_W'(FIFO_DEPTH - BURST_LEN));

    // NOTE: every next-state signal gets its default first so no latch can be inferred.
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        adr_d     = adr_q;
        cnt_d     = cnt_q;
        beat_d    = beat_q;
        busy_d    = busy_q;
        done_d    = done_q;
        abort_d   = abort_q;
        fifo_push = 1'b0;

        if (wr_base) base_d = {csr_di[fml_depth-1:5], 5'b0};
        if (wr_ctrl && csr_di[1]) done_d = 1'b0;
        if (wr_count && !busy_q) begin
            if (csr_di[15:0] != 16'd0) begin
                adr_d  = base_q;
                cnt_d  = csr_di[15:0];
                busy_d = 1'b1;
                done_d = 1'b0;
            end else begin
                cnt_d  = '0;
                done_d = 1'b1;
            end
        end
        if (abort_req && busy_q) abort_d = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (busy_q && abort_req) begin
                    cnt_d = '0; busy_d = 1'b0; done_d = 1'b1; abort_d = 1'b0;
                end else if (busy_q && space_ok) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (fml_ack) begin
                    state_d = ST_DATA;
                    beat_d  = '0;
                end else if (abort_req || abort_q) begin
                    state_d = ST_IDLE;
                    cnt_d = '0; busy_d = 1'b0; done_d = 1'b1; abort_d = 1'b0;
                end
            end
            ST_DATA: begin
                fifo_push = 1'b1;
                beat_d    = beat_q + BEAT_W'(1);
                if (beat_q == BEAT_W'(BURST_LEN - 1)) begin
                    adr_d = adr_q + fml_depth'(32);
                    cnt_d = cnt_q - 16'd1;
                    if (abort_q || abort_req || cnt_q == 16'd1) begin
                        state_d = ST_IDLE;
                        cnt_d = '0; busy_d = 1'b0; done_d = 1'b1; abort_d = 1'b0;
                    end else if (space_ok) begin
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        csr_do_d = '0;
        if (csr_sel) begin
            case (csr_a[1:0])
                CSR_BASE:  csr_do_d = 32'(base_q);
                CSR_COUNT: csr_do_d = {16'd0, cnt_q};
                CSR_CTRL:  csr_do_d = {30'd0, done_q, busy_q};
                default:   csr_do_d = '0;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= ST_IDLE;
            base_q   <= '0;
            adr_q    <= '0;
            cnt_q    <= '0;
            beat_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            abort_q  <= 1'b0;
            csr_do_q <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            adr_q    <= adr_d;
            cnt_q    <= cnt_d;
            beat_q   <= beat_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            abort_q  <= abort_d;
            csr_do_q <= csr_do_d;
        end
    end

    assign fml_stb   = (state_q == ST_REQ);
    assign fml_we    = 1'b0;
    assign fml_sel   = 8'hff;
    assign fml_adr   = adr_q;
    assign csr_do    = csr_do_q;
    assign str_valid = !fifo_empty;

    fml_dmard_fifo u_fifo (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .push_i    (fifo_push),
        .data_i    (fml_di),
        .pop_i     (str_ready),
        .data_o    (str_data),
        .empty_o   (fifo_empty),
        .level_o   (fifo_level)
    );

`ifdef FML_DMARD_IRQ_EN
    logic irq_q;
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) irq_q <= 1'b0;
        else            irq_q <= done_d && !done_q;
    end
    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

endmodule
